// File: rtl/comb_gates_pkg.sv
// Shared types and sizing helpers for the chunked AND/OR reduction sequencer.
package comb_gates_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of CHUNK-wide slices needed to cover an NBITS word.
    function automatic int calc_nchunk(input int nbits, input int chunk);
        return (nbits + chunk - 1) / chunk;
    endfunction

    // Width of the chunk index counter (at least one bit).
    function automatic int calc_idx_w(input int nchunk);
        return (nchunk > 1) ? $clog2(nchunk) : 1;
    endfunction

    // Width of the chunks-consumed count, which must be able to hold NCHUNK.
    function automatic int calc_cnt_w(input int nchunk);
        return (nchunk > 1) ? $clog2(nchunk + 1) : 1;
    endfunction

endpackage

// File: rtl/comb_gates_chunk_reduce.sv
// Combinational CHUNK-bit AND/OR reducer. Lanes with mask=0 lie past the end of
// the word: they read as 1 for the AND and as 0 for the OR so they never change
// the result.
module comb_gates_chunk_reduce #(
    parameter int W = 25
) (
    input  logic [W-1:0] in_,
    input  logic [W-1:0] mask,
    output logic         and_out,
    output logic         or_out
);

    // Fold the valid lanes of the slice, neutralising the padding lanes.
    always_comb begin
        and_out = &(in_ | ~mask);
        or_out  = |(in_ & mask);
    end

endmodule

// File: rtl/comb_gates_seq_reduce_ctrl.sv
// Sequencer that folds a wide word through one narrow reducer, one slice per
// cycle, and presents AND/NAND/OR/NOR of the whole word on a valid/ready port.
module comb_gates_seq_reduce_ctrl
    import comb_gates_pkg::*;
#(
    parameter  int NBITS      = 100,
    parameter  int CHUNK      = 25,
    parameter  int EARLY_EXIT = 1,
    localparam int NCHUNK     = calc_nchunk(NBITS, CHUNK),
    localparam int CNT_W      = calc_cnt_w(NCHUNK)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_val,
    output logic             in_rdy,
    input  logic [NBITS-1:0] in_,
    output logic             out_val,
    input  logic             out_rdy,
    output logic             out_and,
    output logic             out_nand,
    output logic             out_or,
    output logic             out_nor,
    output logic [CNT_W-1:0] out_chunks
);

    localparam int IDX_W = calc_idx_w(NCHUNK);
    localparam int WPAD  = NCHUNK * CHUNK;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [WPAD-1:0]  word_reg;
    logic             acc_and;
    logic             acc_or;

    logic [CHUNK-1:0] chunk_bits;
    logic [CHUNK-1:0] chunk_mask;
    logic             chunk_and;
    logic             chunk_or;
    logic             next_and;
    logic             next_or;
    logic             finish;

    // Select the current slice and mark which of its lanes hold real word bits.
    always_comb begin
        chunk_bits = CHUNK'(word_reg >> (int'(idx) * CHUNK));
        chunk_mask = '0;
        for (int i = 0; i < CHUNK; i++) begin
            chunk_mask[i] = ((int'(idx) * CHUNK + i) < NBITS);
        end
    end

    comb_gates_chunk_reduce #(
        .W (CHUNK)
    ) u_chunk_reduce (
        .in_     (chunk_bits),
        .mask    (chunk_mask),
        .and_out (chunk_and),
        .or_out  (chunk_or)
    );

    // Post-fold accumulator values and the decision to stop folding.
    always_comb begin
        next_and = acc_and & chunk_and;
        next_or  = acc_or | chunk_or;
        finish   = (idx == LAST_IDX) ||
                   ((EARLY_EXIT != 0) && !next_and && next_or);
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            idx        <= '0;
            word_reg   <= '0;
            acc_and    <= 1'b0;
            acc_or     <= 1'b0;
            in_rdy     <= 1'b1;
            out_val    <= 1'b0;
            out_and    <= 1'b0;
            out_nand   <= 1'b0;
            out_or     <= 1'b0;
            out_nor    <= 1'b0;
            out_chunks <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_val && in_rdy) begin
                        word_reg <= WPAD'(in_);
                        idx      <= '0;
                        acc_and  <= 1'b1;
                        acc_or   <= 1'b0;
                        in_rdy   <= 1'b0;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    acc_and <= next_and;
                    acc_or  <= next_or;
                    idx     <= idx + IDX_W'(1);
                    if (finish) begin
                        state      <= DONE;
                        out_val    <= 1'b1;
                        out_and    <= next_and;
                        out_nand   <= ~next_and;
                        out_or     <= next_or;
                        out_nor    <= ~next_or;
                        out_chunks <= CNT_W'(idx) + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (out_rdy) begin
                        state      <= IDLE;
                        in_rdy     <= 1'b1;
                        out_val    <= 1'b0;
                        out_and    <= 1'b0;
                        out_nand   <= 1'b0;
                        out_or     <= 1'b0;
                        out_nor    <= 1'b0;
                        out_chunks <= '0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    in_rdy <= 1'b1;
                end
            endcase
        end
    end

endmodule
